// File: rtl/hwpe_ctrl_periph_arbiter_if.sv
// Peripheral-bus bundle between NumIn initiators, the arbiter and one target.
// Signal suffixes are written from the arbiter's point of view:
//   in_*   initiator side (req/add/wen/be/data/id in, gnt/r_data/r_valid/r_id out)
//   out_*  target side    (req/add/wen/be/data/id out, gnt/r_data/r_valid/r_id in)
// Modports:
//   slave  - used by the arbiter
//   master - used by whatever drives initiators and models the target
interface hwpe_ctrl_periph_arbiter_if #(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 8
);
    localparam int unsigned BeWidth = DataWidth / 8;

    logic [NumIn-1:0]           in_req_i;
    logic [NumIn*AddrWidth-1:0] in_add_i;
    logic [NumIn-1:0]           in_wen_i;
    logic [NumIn*BeWidth-1:0]   in_be_i;
    logic [NumIn*DataWidth-1:0] in_data_i;
    logic [NumIn*IdWidth-1:0]   in_id_i;
    logic [NumIn-1:0]           in_gnt_o;
    logic [DataWidth-1:0]       in_r_data_o;
    logic [NumIn-1:0]           in_r_valid_o;
    logic [IdWidth-1:0]         in_r_id_o;

    logic                       out_req_o;
    logic [AddrWidth-1:0]       out_add_o;
    logic                       out_wen_o;
    logic [BeWidth-1:0]         out_be_o;
    logic [DataWidth-1:0]       out_data_o;
    logic [IdWidth-1:0]         out_id_o;
    logic                       out_gnt_i;
    logic [DataWidth-1:0]       out_r_data_i;
    logic                       out_r_valid_i;
    logic [IdWidth-1:0]         out_r_id_i;

    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i, in_id_i,
        output in_gnt_o, in_r_data_o, in_r_valid_o, in_r_id_o,
        output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o,
        input  out_gnt_i, out_r_data_i, out_r_valid_i, out_r_id_i
    );

    modport master (
        output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i, in_id_i,
        input  in_gnt_o, in_r_data_o, in_r_valid_o, in_r_id_o,
        input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o, out_id_o,
        output out_gnt_i, out_r_data_i, out_r_valid_i, out_r_id_i
    );
endinterface

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin arbiter sharing one peripheral-bus target among NumIn initiators.
// Winner indices of granted requests are queued in an in-order FIFO so each
// target response is steered back to the initiator that issued it.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   bus            hwpe_ctrl_periph_arbiter_if.slave (initiator + target channels)
//   err_o          sticky: response seen while no request was outstanding
//   stall_cnt_o    (HWPE_CTRL_PERIPH_ARB_STATS_EN) cycles with out_req_o & !out_gnt_i, saturating
//   txn_cnt_o      (HWPE_CTRL_PERIPH_ARB_STATS_EN) completed handshakes, saturating
// Optional feature macro: HWPE_CTRL_PERIPH_ARB_STATS_EN
module hwpe_ctrl_periph_arbiter #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 8,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    hwpe_ctrl_periph_arbiter_if.slave        bus,
    output logic                             err_o
`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
    ,
    output logic [15:0]                      stall_cnt_o,
    output logic [15:0]                      txn_cnt_o
`endif
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned PtrW    = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned IdxW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] winner;
    logic [PtrW:0]   scan_idx;
    logic            found;
    logic [PtrW-1:0] fifo_q [MaxOutstanding];
    logic [IdxW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            fifo_full, fifo_empty, can_issue, req_int, handshake, pop;

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    // A response popping this cycle frees the slot the new request needs.
    assign can_issue  = !fifo_full || bus.out_r_valid_i;
    assign req_int    = (|bus.in_req_i) && can_issue;
    assign handshake  = req_int && bus.out_gnt_i;
    assign pop        = bus.out_r_valid_i && !fifo_empty;

    // First requester at or after ptr_q, wrapping modulo NumIn.
    always_comb begin
        winner   = ptr_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NumIn; i++) begin
            scan_idx = {1'b0, ptr_q} + (PtrW+1)'(i);
            if (scan_idx >= (PtrW+1)'(NumIn)) begin
                scan_idx = scan_idx - (PtrW+1)'(NumIn);
            end
            if (!found && bus.in_req_i[scan_idx[PtrW-1:0]]) begin
                winner = scan_idx[PtrW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_req_o    = req_int;
        bus.out_add_o    = '0;
        bus.out_wen_o    = 1'b0;
        bus.out_be_o     = '0;
        bus.out_data_o   = '0;
        bus.out_id_o     = '0;
        bus.in_gnt_o     = '0;
        bus.in_r_valid_o = '0;
        for (int k = 0; k < NumIn; k++) begin
            if (winner == PtrW'(k)) begin
                bus.out_add_o  = bus.in_add_i[k*AddrWidth +: AddrWidth];
                bus.out_wen_o  = bus.in_wen_i[k];
                bus.out_be_o   = bus.in_be_i[k*BeWidth +: BeWidth];
                bus.out_data_o = bus.in_data_i[k*DataWidth +: DataWidth];
                bus.out_id_o   = bus.in_id_i[k*IdWidth +: IdWidth];
                bus.in_gnt_o[k] = found && bus.out_gnt_i && can_issue;
            end
            bus.in_r_valid_o[k] = pop && (fifo_q[head_q] == PtrW'(k));
        end
    end

    assign bus.in_r_data_o = bus.out_r_data_i;
    assign bus.in_r_id_o   = bus.out_r_id_i;
    assign err_o           = err_q;

    always_comb begin
        ptr_d  = ptr_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (handshake) begin
            ptr_d  = (winner == PtrW'(NumIn - 1)) ? '0 : winner + PtrW'(1);
            tail_d = (tail_q == IdxW'(MaxOutstanding - 1)) ? '0 : tail_q + IdxW'(1);
        end
        if (pop) begin
            head_d = (head_q == IdxW'(MaxOutstanding - 1)) ? '0 : head_q + IdxW'(1);
        end
        if (bus.out_r_valid_i && fifo_empty) begin
            err_d = 1'b1;
        end
        case ({handshake, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            if (handshake) begin
                fifo_q[tail_q] <= winner;
            end
        end
    end

`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, txn_cnt_q, txn_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        txn_cnt_d   = txn_cnt_q;
        if (req_int && !bus.out_gnt_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (handshake && (txn_cnt_q != 16'hFFFF)) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            txn_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign txn_cnt_o   = txn_cnt_q;
`endif
endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// Self-checking bench for hwpe_ctrl_periph_arbiter: grant owners are queued
// when a handshake is expected and popped when the target responds.
module tb_hwpe_ctrl_periph_arbiter;
    localparam int NumIn          = 4;
    localparam int AddrWidth      = 32;
    localparam int DataWidth      = 32;
    localparam int IdWidth        = 8;
    localparam int MaxOutstanding = 4;
    localparam int BeWidth        = DataWidth / 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic err_o;
`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
    logic [15:0] stall_cnt_o;
    logic [15:0] txn_cnt_o;
`endif

    hwpe_ctrl_periph_arbiter_if #(
        .NumIn(NumIn), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .IdWidth(IdWidth)
    ) bus ();

    hwpe_ctrl_periph_arbiter #(
        .NumIn(NumIn), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
        .IdWidth(IdWidth), .MaxOutstanding(MaxOutstanding)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .bus(bus),
        .err_o(err_o)
`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .txn_cnt_o(txn_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    function automatic logic [NumIn-1:0] oh(input int k);
        logic [NumIn-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [AddrWidth-1:0] addr_of(input int k);
        return 32'h1000_0000 + 32'(k * 16);
    endfunction

    function automatic logic [IdWidth-1:0] id_of(input int k);
        return 8'h40 + 8'(k);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_req_i      = '0;
        bus.out_gnt_i     = 1'b0;
        bus.out_r_valid_i = 1'b0;
        bus.out_r_data_i  = '0;
        bus.out_r_id_i    = '0;
        for (int k = 0; k < NumIn; k++) begin
            bus.in_add_i[k*AddrWidth +: AddrWidth]  = addr_of(k);
            bus.in_id_i[k*IdWidth +: IdWidth]       = id_of(k);
            bus.in_wen_i[k]                         = k[0];
            bus.in_be_i[k*BeWidth +: BeWidth]       = 4'hF;
            bus.in_data_i[k*DataWidth +: DataWidth] = 32'hD000_0000 + 32'(k);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #7;
        rst_ni = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        total++;
        if (bus.out_req_o !== 1'b0) begin
            bad++; $display("FAIL reset_out_req got=%b want=0", bus.out_req_o);
        end
        total++;
        if (bus.in_gnt_o !== 4'b0000 || bus.in_r_valid_o !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt_rvalid got gnt=%b rv=%b want 0000/0000", bus.in_gnt_o, bus.in_r_valid_o);
        end
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL reset_err got=%b want=0", err_o);
        end
`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
        total++;
        if (stall_cnt_o !== 16'd0 || txn_cnt_o !== 16'd0) begin
            bad++; $display("FAIL reset_stats got stall=%0d txn=%0d want 0/0", stall_cnt_o, txn_cnt_o);
        end
`endif
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]         sv;
        logic [IdWidth-1:0] sid0, sid1, tag;
        logic [NumIn-1:0]   want;
        int                 w;
        sv = 2'b00; sid0 = '0; sid1 = '0; tag = '0;
        for (int c = 0; c < 8; c++) begin
            bus.in_req_i      = (c < 5) ? 4'hF : 4'h0;
            bus.out_gnt_i     = 1'b1;
            bus.out_r_valid_i = sv[1];
            bus.out_r_id_i    = sid1;
            bus.out_r_data_i  = {24'h0, sid1} ^ 32'hCAFE_0000;
            #1;
            if (sv[1]) begin
                want = (exp_q.size() > 0) ? oh(exp_q.pop_front()) : 4'b0000;
                total++;
                if (bus.in_r_valid_o !== want || bus.in_r_id_o !== sid1 ||
                    bus.in_r_data_o !== ({24'h0, sid1} ^ 32'hCAFE_0000)) begin
                    bad++; $display("FAIL rr_resp c=%0d got rv=%b id=%h want rv=%b id=%h", c, bus.in_r_valid_o, bus.in_r_id_o, want, sid1);
                end
            end else begin
                total++;
                if (bus.in_r_valid_o !== 4'b0000) begin
                    bad++; $display("FAIL rr_no_resp c=%0d got rv=%b want 0000", c, bus.in_r_valid_o);
                end
            end
            if (c < 5) begin
                w = c % NumIn;
                total++;
                if (bus.in_gnt_o !== oh(w) || bus.out_add_o !== addr_of(w) || bus.out_id_o !== id_of(w)) begin
                    bad++; $display("FAIL rr_grant c=%0d got gnt=%b add=%h id=%h want gnt=%b add=%h id=%h",
                                    c, bus.in_gnt_o, bus.out_add_o, bus.out_id_o, oh(w), addr_of(w), id_of(w));
                end
                exp_q.push_back(w);
                tag = id_of(w);
            end else begin
                total++;
                if (bus.in_gnt_o !== 4'b0000) begin
                    bad++; $display("FAIL rr_idle_gnt c=%0d got=%b want 0000", c, bus.in_gnt_o);
                end
            end
            sv[1] = sv[0];
            sid1  = sid0;
            sv[0] = (c < 5);
            sid0  = tag;
            tick();
        end
        idle_inputs();
    endtask

    // Pointer is 1 on entry (last round-robin grant went to port 0).
    task automatic test_backpressure();
        logic [NumIn-1:0] want;
        bus.in_req_i = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            bus.out_gnt_i = 1'b0;
            #1;
            total++;
            if (bus.in_gnt_o !== 4'b0000 || bus.out_req_o !== 1'b1) begin
                bad++; $display("FAIL bp_stall c=%0d got gnt=%b req=%b want 0000/1", c, bus.in_gnt_o, bus.out_req_o);
            end
            tick();
        end
        bus.out_gnt_i = 1'b1;
        #1;
        total++;
        if (bus.in_gnt_o !== 4'b0100) begin
            bad++; $display("FAIL bp_release got gnt=%b want 0100", bus.in_gnt_o);
        end
        exp_q.push_back(2);
        tick();
        bus.in_req_i      = 4'b0000;
        bus.out_gnt_i     = 1'b0;
        bus.out_r_valid_i = 1'b1;
        #1;
        want = (exp_q.size() > 0) ? oh(exp_q.pop_front()) : 4'b0000;
        total++;
        if (bus.in_r_valid_o !== want) begin
            bad++; $display("FAIL bp_resp got rv=%b want %b", bus.in_r_valid_o, want);
        end
        tick();
        bus.out_r_valid_i = 1'b0;
        bus.in_req_i      = 4'hF;
        bus.out_gnt_i     = 1'b1;
        #1;
        total++;
        if (bus.in_gnt_o !== 4'b1000) begin
            bad++; $display("FAIL bp_ptr_after got gnt=%b want 1000", bus.in_gnt_o);
        end
        exp_q.push_back(3);
        tick();
        bus.in_req_i      = 4'b0000;
        bus.out_r_valid_i = 1'b1;
        #1;
        want = (exp_q.size() > 0) ? oh(exp_q.pop_front()) : 4'b0000;
        total++;
        if (bus.in_r_valid_o !== want) begin
            bad++; $display("FAIL bp_resp2 got rv=%b want %b", bus.in_r_valid_o, want);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        logic [NumIn-1:0] want;
        do_reset();
        bus.in_req_i  = 4'hF;
        bus.out_gnt_i = 1'b1;
        for (int c = 0; c < MaxOutstanding; c++) begin
            #1;
            total++;
            if (bus.in_gnt_o !== oh(c)) begin
                bad++; $display("FAIL full_fill c=%0d got gnt=%b want %b", c, bus.in_gnt_o, oh(c));
            end
            exp_q.push_back(c);
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (bus.out_req_o !== 1'b0 || bus.in_gnt_o !== 4'b0000) begin
                bad++; $display("FAIL full_hold c=%0d got req=%b gnt=%b want 0/0000", c, bus.out_req_o, bus.in_gnt_o);
            end
            tick();
        end
        bus.out_r_valid_i = 1'b1;
        #1;
        want = (exp_q.size() > 0) ? oh(exp_q.pop_front()) : 4'b0000;
        total++;
        if (bus.in_r_valid_o !== want || want !== 4'b0001) begin
            bad++; $display("FAIL full_pop_resp got rv=%b want 0001", bus.in_r_valid_o);
        end
        total++;
        if (bus.out_req_o !== 1'b1 || bus.in_gnt_o !== 4'b0001) begin
            bad++; $display("FAIL full_pop_grant got req=%b gnt=%b want 1/0001", bus.out_req_o, bus.in_gnt_o);
        end
        exp_q.push_back(0);
        tick();
        bus.in_req_i  = 4'b0000;
        bus.out_gnt_i = 1'b0;
        for (int c = 0; c < MaxOutstanding; c++) begin
            #1;
            want = (exp_q.size() > 0) ? oh(exp_q.pop_front()) : 4'b0000;
            total++;
            if (bus.in_r_valid_o !== want) begin
                bad++; $display("FAIL full_drain c=%0d got rv=%b want %b", c, bus.in_r_valid_o, want);
            end
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL full_no_err got=%b want 0", err_o);
        end
    endtask

    task automatic test_spurious();
        bus.out_r_valid_i = 1'b1;
        #1;
        total++;
        if (bus.in_r_valid_o !== 4'b0000) begin
            bad++; $display("FAIL spur_rvalid got=%b want 0000", bus.in_r_valid_o);
        end
        tick();
        bus.out_r_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (err_o !== 1'b1) begin
                bad++; $display("FAIL spur_err_sticky c=%0d got=%b want 1", c, err_o);
            end
            tick();
        end
        do_reset();
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL spur_err_clear got=%b want 0", err_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [NumIn-1:0] want;
        do_reset();
        bus.in_req_i  = 4'hF;
        bus.out_gnt_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (bus.in_gnt_o !== oh(c)) begin
                bad++; $display("FAIL mid_grant c=%0d got gnt=%b want %b", c, bus.in_gnt_o, oh(c));
            end
            tick();
        end
        idle_inputs();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        exp_q.delete();
        tick();
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL mid_err_after_rst got=%b want 0", err_o);
        end
        bus.out_r_valid_i = 1'b1;
        #1;
        total++;
        if (bus.in_r_valid_o !== 4'b0000) begin
            bad++; $display("FAIL mid_stale_rvalid got=%b want 0000", bus.in_r_valid_o);
        end
        tick();
        bus.out_r_valid_i = 1'b0;
        total++;
        if (err_o !== 1'b1) begin
            bad++; $display("FAIL mid_stale_err got=%b want 1", err_o);
        end
        bus.in_req_i  = 4'hF;
        bus.out_gnt_i = 1'b1;
        #1;
        total++;
        if (bus.in_gnt_o !== 4'b0001) begin
            bad++; $display("FAIL mid_ptr_zero got gnt=%b want 0001", bus.in_gnt_o);
        end
        exp_q.push_back(0);
        tick();
        idle_inputs();
        bus.out_r_valid_i = 1'b1;
        #1;
        want = (exp_q.size() > 0) ? oh(exp_q.pop_front()) : 4'b0000;
        total++;
        if (bus.in_r_valid_o !== want) begin
            bad++; $display("FAIL mid_resp got rv=%b want %b", bus.in_r_valid_o, want);
        end
        tick();
        idle_inputs();
    endtask

`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.in_req_i  = 4'b0001;
        bus.out_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        bus.out_gnt_i = 1'b1;
        tick();
        idle_inputs();
        #1;
        total++;
        if (stall_cnt_o !== 16'd3 || txn_cnt_o !== 16'd1) begin
            bad++; $display("FAIL stats got stall=%0d txn=%0d want 3/1", stall_cnt_o, txn_cnt_o);
        end
        bus.out_r_valid_i = 1'b1;
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_fifo_full();
        test_spurious();
        test_reset_mid();
`ifdef HWPE_CTRL_PERIPH_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
